// File: rtl/vote_frame_collector.sv
// Serial-to-parallel vote collector: gathers N vote bits (bit 0 first) into a
// frame and holds it on frame_out under a valid/ready handshake.
module vote_frame_collector #(
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  input  logic                       flush,
  output logic [N-1:0]               frame_out,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [$clog2(N+1)-1:0]     bit_count,
  output logic [7:0]                 frame_count,
  output logic                       dbg_state
);

  localparam int CW = $clog2(N+1);

  // Handshakes: a transfer happens on a rising edge where valid && ready were
  // both high during the preceding cycle; ready never depends on valid.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    frame_q, frame_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      fcount_q, fcount_d;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    count_d  = count_q;
    fcount_d = fcount_q;
    case (state_q)
      COLLECT: begin
        // Flush wins over a vote presented in the same cycle.
        if (flush) begin
          frame_d = '0;
          count_d = '0;
        end else if (bit_valid) begin
          for (int i = 0; i < N; i++) begin
            if (CW'(i) == count_q) frame_d[i] = bit_in;
          end
          if (count_q == CW'(N - 1)) begin
            state_d = FULL;
            count_d = CW'(N);
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (frame_ready) begin
          state_d  = COLLECT;
          frame_d  = '0;
          count_d  = '0;
          fcount_d = fcount_q + 8'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      frame_q  <= '0;
      count_q  <= '0;
      fcount_q <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      count_q  <= count_d;
      fcount_q <= fcount_d;
    end
  end

  assign bit_ready   = (state_q == COLLECT);
  assign frame_valid = (state_q == FULL);
  assign frame_out   = frame_q;
  assign bit_count   = count_q;
  assign frame_count = fcount_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vote_frame_collector.sv
// Directed bench for vote_frame_collector (N=8 and N=3) with a frame scoreboard.
module tb_vote_frame_collector;

  logic       clk;
  logic       rst_n;
  logic       bit_in, bit_valid, bit_ready, flush;
  logic [7:0] frame_out;
  logic       frame_valid, frame_ready;
  logic [3:0] bit_count;
  logic [7:0] frame_count;
  logic       dbg_state;

  logic       bit_in_3, bit_valid_3, bit_ready_3, flush_3;
  logic [2:0] frame_out_3;
  logic       frame_valid_3, frame_ready_3;
  logic [1:0] bit_count_3;
  logic [7:0] frame_count_3;
  logic       dbg_state_3;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  vote_frame_collector #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush(flush), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .bit_count(bit_count), .frame_count(frame_count), .dbg_state(dbg_state)
  );

  vote_frame_collector #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in_3), .bit_valid(bit_valid_3),
    .bit_ready(bit_ready_3), .flush(flush_3), .frame_out(frame_out_3),
    .frame_valid(frame_valid_3), .frame_ready(frame_ready_3),
    .bit_count(bit_count_3), .frame_count(frame_count_3), .dbg_state(dbg_state_3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      drive_slot();
      bit_valid = 1'b1;
      bit_in    = v[i];
    end
    drive_slot();
    bit_valid = 1'b0;
  endtask

  task automatic deliver(input logic [7:0] v);
    exp_q.push_back(v);
    send_bits(v, 8);
    frame_ready = 1'b1;
    drive_slot();
    frame_ready = 1'b0;
  endtask

  // monitor: pops the scoreboard whenever a frame is handed downstream
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got 0x%0h with empty expected queue", frame_out);
      end else begin
        check("frame_data", 32'(frame_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
    bit_in_3 = 1'b0; bit_valid_3 = 1'b0; flush_3 = 1'b0; frame_ready_3 = 1'b0;
    #12 rst_n = 1'b1;

    // asynchronous reset mid-cycle during a partial frame
    send_bits(8'b0000_0101, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_bit_ready",   32'(bit_ready), 1);
    check("rst_bit_count",   32'(bit_count), 0);
    check("rst_frame_out",   32'(frame_out), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    @(negedge clk) rst_n = 1'b1;

    // full frame 1,1,0,1,0,0,1,1 -> 0xCB
    exp_q.push_back(8'hCB);
    send_bits(8'hCB, 8);
    @(negedge clk);
    check("full_frame_out",   32'(frame_out), 32'hCB);
    check("full_frame_valid", 32'(frame_valid), 1);
    check("full_bit_count",   32'(bit_count), 8);
    check("full_bit_ready",   32'(bit_ready), 0);

    // backpressure: votes offered while FULL are not taken
    drive_slot();
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_frame_out", 32'(frame_out), 32'hCB);
      check("bp_bit_count", 32'(bit_count), 8);
    end
    drive_slot();
    bit_valid   = 1'b0;
    frame_ready = 1'b1;
    drive_slot();
    frame_ready = 1'b0;
    @(negedge clk);
    check("hs_frame_valid", 32'(frame_valid), 0);
    check("hs_frame_count", 32'(frame_count), 1);
    check("hs_bit_count",   32'(bit_count), 0);
    check("hs_bit_ready",   32'(bit_ready), 1);

    // flush with a simultaneous vote drops the vote and the partial frame
    send_bits(8'h07, 3);
    @(negedge clk);
    check("pre_flush_count", 32'(bit_count), 3);
    drive_slot();
    flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    drive_slot();
    flush = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    check("flush_bit_count", 32'(bit_count), 0);
    check("flush_frame_out", 32'(frame_out), 0);
    deliver(8'h5A);
    @(negedge clk);
    check("post_flush_count", 32'(frame_count), 2);

    // reset while a frame is pending: frame is discarded, not counted
    send_bits(8'hFF, 8);
    @(negedge clk);
    check("pend_frame_valid", 32'(frame_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstfull_frame_valid", 32'(frame_valid), 0);
    check("rstfull_frame_count", 32'(frame_count), 0);
    check("rstfull_frame_out",   32'(frame_out), 0);
    @(negedge clk) rst_n = 1'b1;

    // 256 frames: counter wraps 255 -> 0
    for (int f = 0; f < 255; f++) deliver(8'(f * 37 + 1));
    @(negedge clk);
    check("wrap_count_255", 32'(frame_count), 255);
    deliver(8'h3C);
    @(negedge clk);
    check("wrap_count_0", 32'(frame_count), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    // N=3: votes 0,1,1 -> 3'b110
    drive_slot(); bit_valid_3 = 1'b1; bit_in_3 = 1'b0;
    drive_slot(); bit_in_3 = 1'b1;
    drive_slot(); bit_in_3 = 1'b1;
    drive_slot(); bit_valid_3 = 1'b0;
    @(negedge clk);
    check("n3_frame_out",   32'(frame_out_3), 32'b110);
    check("n3_bit_count",   32'(bit_count_3), 3);
    check("n3_frame_valid", 32'(frame_valid_3), 1);
    check("n3_bit_ready",   32'(bit_ready_3), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
